// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the ALU, the result stage and writeback.
// The slave modport is the stage itself; master is the surrounding pipeline.
interface alu_result_stage_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned RD_W  = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_result;
    logic             in_n;
    logic             in_z;
    logic             in_v;
    logic             in_c;
    logic [RD_W-1:0]  in_rd;
    logic             in_wen;
    logic             in_set_flags;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [RD_W-1:0]  out_rd;
    logic             out_wen;

    modport slave (
        input  in_valid, in_result, in_n, in_z, in_v, in_c, in_rd, in_wen, in_set_flags,
        input  out_ready,
        output in_ready, out_valid, out_result, out_rd, out_wen
    );

    modport master (
        output in_valid, in_result, in_n, in_z, in_v, in_c, in_rd, in_wen, in_set_flags,
        output out_ready,
        input  in_ready, out_valid, out_result, out_rd, out_wen
    );
endinterface

// File: rtl/alu_result_stage.sv
// ALU result stage: in-order result buffer towards writeback, plus the NZCV
// status register, sticky overflow and a retired-result counter.
module alu_result_stage #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned RD_W  = 5,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    alu_result_stage_if.slave   bus,
    input  logic                flag_clear,
    output logic [3:0]          status_nzcv,
    output logic                sticky_v,
    output logic [CNT_W-1:0]    retired_count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = DEPTH[PTR_W:0];

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [RD_W-1:0]  rd;
        logic             wen;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q, count_d;
    logic [3:0]       nzcv_q;
    logic             sticky_q;
    logic [CNT_W-1:0] retired_q;
    logic             push, pop;
    entry_t           head;

    // Handshake status depends on registered occupancy only.
    assign bus.in_ready  = (count_q != DEPTH_CNT);
    assign bus.out_valid = (count_q != '0);

    assign push = bus.in_valid & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;

    assign head           = mem_q[rd_ptr_q];
    assign bus.out_result = head.result;
    assign bus.out_rd     = head.rd;
    assign bus.out_wen    = head.wen;

    assign status_nzcv   = nzcv_q;
    assign sticky_v      = sticky_q;
    assign retired_count = retired_q;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is reset too so the head outputs read zero straight out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            retired_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= '{result: bus.in_result, rd: bus.in_rd, wen: bus.in_wen};
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + PTR_W'(1);
                retired_q <= retired_q + CNT_W'(1);
            end
            count_q <= count_d;
        end
    end

    // A flag-setting push wins over flag_clear in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nzcv_q   <= 4'b0000;
            sticky_q <= 1'b0;
        end else if (push && bus.in_set_flags) begin
            nzcv_q   <= {bus.in_n, bus.in_z, bus.in_c, bus.in_v};
            sticky_q <= sticky_q | bus.in_v;
        end else if (flag_clear) begin
            nzcv_q   <= 4'b0000;
            sticky_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage.
module tb_alu_result_stage;
    logic        clk;
    logic        reset;
    logic        flag_clear;
    logic [3:0]  status_nzcv;
    logic        sticky_v;
    logic [15:0] retired_count;
    int          checks;
    int          errors;

    alu_result_stage_if #(.WIDTH(32), .RD_W(5)) bus ();

    alu_result_stage #(
        .WIDTH(32),
        .RD_W(5),
        .DEPTH(2),
        .CNT_W(16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .flag_clear   (flag_clear),
        .status_nzcv  (status_nzcv),
        .sticky_v     (sticky_v),
        .retired_count(retired_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic valid, input logic [31:0] res, input logic [4:0] rd,
                         input logic wen, input logic sf, input logic [3:0] nzcv);
        bus.in_valid     = valid;
        bus.in_result    = res;
        bus.in_rd        = rd;
        bus.in_wen       = wen;
        bus.in_set_flags = sf;
        {bus.in_n, bus.in_z, bus.in_c, bus.in_v} = nzcv;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
        end
        checks++;
        if ({bus.out_result, bus.out_rd, bus.out_wen} !== 38'd0) begin
            errors++; $display("FAIL reset_out_fields got %h/%h/%b want 0/0/0",
                               bus.out_result, bus.out_rd, bus.out_wen);
        end
        checks++;
        if ({status_nzcv, sticky_v, retired_count} !== 21'd0) begin
            errors++; $display("FAIL reset_status got nzcv=%b sticky=%b ret=%0d want 0/0/0",
                               status_nzcv, sticky_v, retired_count);
        end
    endtask

    task automatic test_single();
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h0000_0005, 5'd3, 1'b1, 1'b1, 4'b0000);
        tick();
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 4'b0000);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd5 || bus.out_rd !== 5'd3 ||
            bus.out_wen !== 1'b1) begin
            errors++; $display("FAIL single_head got v=%b res=%h rd=%0d wen=%b want 1/5/3/1",
                               bus.out_valid, bus.out_result, bus.out_rd, bus.out_wen);
        end
        checks++;
        if (status_nzcv !== 4'b0000) begin
            errors++; $display("FAIL single_nzcv got %b want 0000", status_nzcv);
        end
        tick();
        checks++;
        if (retired_count !== 16'd1 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL single_retire got ret=%0d v=%b want 1/0",
                               retired_count, bus.out_valid);
        end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        drive(1'b1, 32'hAAAA_AAAA, 5'd1, 1'b1, 1'b0, 4'b0000);
        tick();
        drive(1'b1, 32'h5555_5555, 5'd2, 1'b0, 1'b0, 4'b0000);
        tick();
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_full_ready got %b want 0", bus.in_ready);
        end
        drive(1'b1, 32'hDEAD_BEEF, 5'd7, 1'b1, 1'b0, 4'b0000);
        tick();
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_result !== 32'hAAAA_AAAA || bus.out_rd !== 5'd1) begin
            errors++; $display("FAIL bp_stall got rdy=%b res=%h rd=%0d want 0/AAAAAAAA/1",
                               bus.in_ready, bus.out_result, bus.out_rd);
        end
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 4'b0000);
        bus.out_ready = 1'b1;
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_result !== 32'h5555_5555 ||
            bus.out_wen !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_second got v=%b res=%h wen=%b rdy=%b want 1/55555555/0/1",
                               bus.out_valid, bus.out_result, bus.out_wen, bus.in_ready);
        end
        tick();
        checks++;
        if (bus.out_valid !== 1'b0 || retired_count !== 16'd3) begin
            errors++; $display("FAIL bp_drain got v=%b ret=%0d want 0/3",
                               bus.out_valid, retired_count);
        end
    endtask

    task automatic test_flags();
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h8000_0000, 5'd4, 1'b1, 1'b1, 4'b1001);
        tick();
        checks++;
        if (status_nzcv !== 4'b1001 || sticky_v !== 1'b1) begin
            errors++; $display("FAIL flags_first got nzcv=%b sticky=%b want 1001/1",
                               status_nzcv, sticky_v);
        end
        drive(1'b1, 32'h0, 5'd5, 1'b1, 1'b1, 4'b0100);
        tick();
        checks++;
        if (status_nzcv !== 4'b0100 || sticky_v !== 1'b1) begin
            errors++; $display("FAIL flags_sticky got nzcv=%b sticky=%b want 0100/1",
                               status_nzcv, sticky_v);
        end
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 4'b0000);
        flag_clear = 1'b1;
        tick();
        flag_clear = 1'b0;
        checks++;
        if (status_nzcv !== 4'b0000 || sticky_v !== 1'b0 || retired_count !== 16'd5) begin
            errors++; $display("FAIL flags_clear got nzcv=%b sticky=%b ret=%0d want 0000/0/5",
                               status_nzcv, sticky_v, retired_count);
        end
    endtask

    task automatic test_priority();
        bus.out_ready = 1'b1;
        flag_clear = 1'b1;
        drive(1'b1, 32'h1, 5'd6, 1'b1, 1'b1, 4'b0010);
        tick();
        flag_clear = 1'b0;
        checks++;
        if (status_nzcv !== 4'b0010) begin
            errors++; $display("FAIL prio_setflags got %b want 0010", status_nzcv);
        end
        drive(1'b1, 32'h2, 5'd7, 1'b1, 1'b0, 4'b1101);
        tick();
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 4'b0000);
        checks++;
        if (status_nzcv !== 4'b0010 || sticky_v !== 1'b0) begin
            errors++; $display("FAIL prio_noflags got nzcv=%b sticky=%b want 0010/0",
                               status_nzcv, sticky_v);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'(i), 5'(i), 1'b1, 1'b0, 4'b0000);
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_result !== 32'(i) || bus.in_ready !== 1'b1) begin
                errors++; $display("FAIL stream_%0d got v=%b res=%h rdy=%b want 1/%h/1",
                                   i, bus.out_valid, bus.out_result, bus.in_ready, 32'(i));
            end
        end
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 4'b0000);
        tick();
        checks++;
        if (retired_count !== 16'd10 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL stream_count got ret=%0d v=%b want 10/0",
                               retired_count, bus.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h11, 5'd1, 1'b1, 1'b1, 4'b1000);
        tick();
        drive(1'b1, 32'h22, 5'd2, 1'b1, 1'b0, 4'b0000);
        tick();
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 4'b0000);
        checks++;
        if (bus.in_ready !== 1'b0 || status_nzcv !== 4'b1000) begin
            errors++; $display("FAIL mid_full got rdy=%b nzcv=%b want 0/1000",
                               bus.in_ready, status_nzcv);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || retired_count !== 16'd0 ||
            status_nzcv !== 4'b0000 || bus.out_result !== 32'd0) begin
            errors++; $display("FAIL mid_async got v=%b rdy=%b ret=%0d nzcv=%b res=%h want 0/1/0/0000/0",
                               bus.out_valid, bus.in_ready, retired_count, status_nzcv,
                               bus.out_result);
        end
        #1;
        reset = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b0 || retired_count !== 16'd0) begin
                errors++; $display("FAIL mid_stale_%0d got v=%b ret=%0d want 0/0",
                                   i, bus.out_valid, retired_count);
            end
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        flag_clear = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 4'b0000);
        #12;
        test_reset();
        reset = 1'b0;
        test_single();
        test_backpressure();
        test_flags();
        test_priority();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
